// File: rtl/cpu_core_mc_if.sv
// Bus bundle between cpu_core_mc and its instruction/data memories.
// master: the core (drives requests, addresses, store data).
// slave : the memory side (drives acks and read data).
//   imem_req/imem_addr -> fetch request, imem_rdata/imem_ack <- fetch reply
//   dmem_req/dmem_we/dmem_addr/dmem_wdata -> data access, dmem_rdata/dmem_ack <- reply
interface cpu_core_mc_if #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 6
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [15:0]        imem_rdata;
  logic               imem_ack;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: FETCH -> EXEC (-> MEM) -> FETCH, with req/ack
// memory handshakes so wait states are tolerated. Eight GPRs, {N,Z,C}
// flags, relative branches, sticky halt / illegal-opcode stop.
// Ports:
//   clk, reset   clock, async active-high reset
//   bus          master side of cpu_core_mc_if (imem/dmem handshakes)
//   pc_out       current PC
//   flags        {N, Z, C}
//   halted       core stopped
//   illegal      stop caused by an illegal opcode
module cpu_core_mc #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  cpu_core_mc_if.master   bus,
  output logic [PC_W-1:0] pc_out,
  output logic [2:0]      flags,
  output logic            halted,
  output logic            illegal
);
  localparam logic [3:0] OP_ADD  = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR   = 4'h4, OP_XOR = 4'h5, OP_ADDI = 4'h6,
                         OP_LDI  = 4'h7, OP_LD  = 4'h8, OP_ST  = 4'h9,
                         OP_JMP  = 4'hA, OP_BZ  = 4'hB, OP_BN  = 4'hC,
                         OP_HALT = 4'hD, OP_IL0 = 4'hE, OP_IL1 = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

  state_e                 state_q;
  logic [PC_W-1:0]        pc_q;
  logic [7:0][DATA_W-1:0] regs_q;
  logic [2:0]             flags_q;
  logic [15:0]            ir_q;
  logic                   imem_req_q, dmem_req_q, dmem_we_q;
  logic [DADDR_W-1:0]     dmem_addr_q;
  logic [DATA_W-1:0]      dmem_wdata_q;
  logic                   halted_q, illegal_q;

  // Decode fields of the latched instruction
  logic [3:0] op;
  logic [2:0] rd, rs;
  logic [5:0] imm;
  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:9];
  assign rs  = ir_q[8:6];
  assign imm = ir_q[5:0];

  logic [DATA_W-1:0] rd_v, rs_v, imm_s, imm_z;
  assign rd_v  = regs_q[rd];
  assign rs_v  = regs_q[rs];
  assign imm_s = DATA_W'($signed(imm));
  assign imm_z = DATA_W'(imm);

  // Next-PC candidates and data address; all wrap by truncation
  logic [PC_W-1:0]    pc_seq_d, br_tgt_d, jmp_tgt_d;
  logic [DADDR_W-1:0] daddr_d;
  assign pc_seq_d  = pc_q + PC_W'(1);
  assign br_tgt_d  = pc_seq_d + PC_W'($signed(imm));
  assign jmp_tgt_d = PC_W'(rs_v) + PC_W'(imm);
  assign daddr_d   = DADDR_W'(rs_v) + DADDR_W'(imm);

  // ALU: one extra bit carries carry-out (ADD/ADDI) or borrow (SUB)
  logic [DATA_W:0]   ext_d;
  logic [DATA_W-1:0] alu_d;
  logic              alu_c_d;
  always_comb begin
    ext_d   = '0;
    alu_d   = '0;
    alu_c_d = 1'b0;
    case (op)
      OP_ADD:  ext_d = {1'b0, rd_v} + {1'b0, rs_v};
      OP_SUB:  ext_d = {1'b0, rd_v} - {1'b0, rs_v};
      OP_ADDI: ext_d = {1'b0, rd_v} + {1'b0, imm_s};
      default: ;
    endcase
    case (op)
      OP_ADD, OP_SUB, OP_ADDI: begin
        alu_d   = ext_d[DATA_W-1:0];
        alu_c_d = ext_d[DATA_W];
      end
      OP_AND:  alu_d = rd_v & rs_v;
      OP_OR:   alu_d = rd_v | rs_v;
      OP_XOR:  alu_d = rd_v ^ rs_v;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      regs_q       <= '0;
      flags_q      <= '0;
      ir_q         <= '0;
      imem_req_q   <= 1'b1;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_req_q && bus.imem_ack) begin
            ir_q       <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Default completion: sequential PC and back to fetch;
          // the cases below override for memory, control flow and stop.
          pc_q       <= pc_seq_d;
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
              regs_q[rd] <= alu_d;
              flags_q    <= {alu_d[DATA_W-1], alu_d == '0, alu_c_d};
            end
            OP_LDI: regs_q[rd] <= imm_z;
            OP_LD, OP_ST: begin
              pc_q         <= pc_q;
              state_q      <= S_MEM;
              imem_req_q   <= 1'b0;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= (op == OP_ST);
              dmem_addr_q  <= daddr_d;
              dmem_wdata_q <= rd_v;
            end
            OP_JMP: pc_q <= jmp_tgt_d;
            OP_BZ:  if (flags_q[1]) pc_q <= br_tgt_d;
            OP_BN:  if (flags_q[2]) pc_q <= br_tgt_d;
            OP_HALT, OP_IL0, OP_IL1: begin
              pc_q       <= pc_q;
              state_q    <= S_HALT;
              imem_req_q <= 1'b0;
              halted_q   <= 1'b1;
              illegal_q  <= (op != OP_HALT);
            end
            default: ;  // NOP
          endcase
        end
        S_MEM: begin
          if (dmem_req_q && bus.dmem_ack) begin
            if (!dmem_we_q) regs_q[rd] <= bus.dmem_rdata;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            pc_q       <= pc_seq_d;
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        default: ;  // S_HALT: sticky until reset
      endcase
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign pc_out         = pc_q;
  assign flags          = flags_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;
endmodule

// File: tb/tb_cpu_core_mc.sv
module tb_cpu_core_mc;
  logic       clk;
  logic       reset;
  logic [7:0] pc_out;
  logic [2:0] flags;
  logic       halted, illegal;

  cpu_core_mc_if #(.DATA_W(8), .PC_W(8), .DADDR_W(6)) bus ();

  cpu_core_mc #(.DATA_W(8), .PC_W(8), .DADDR_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .pc_out  (pc_out),
    .flags   (flags),
    .halted  (halted),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] imem [256];
  logic [7:0]  dmem [64];
  logic [7:0]  flog [$];
  int          iwait = 0, dwait = 0;
  bit          resp_en = 1'b0;
  int          st_cnt = 0, stab_err = 0;
  logic [5:0]  last_st_addr;
  logic [7:0]  last_st_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [5:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Memory responder: decides acks on the falling edge so the core samples
  // them on the next rising edge; also checks request stability during waits.
  initial begin
    int          icnt, dcnt;
    logic [7:0]  i_addr0, d_pc0;
    logic [5:0]  d_addr0;
    logic [7:0]  d_wdata0;
    logic        d_we0;
    icnt = 0; dcnt = 0;
    i_addr0 = '0; d_pc0 = '0; d_addr0 = '0; d_wdata0 = '0; d_we0 = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        if (!reset && bus.imem_req) begin
          if (icnt == 0) i_addr0 = bus.imem_addr;
          else if (bus.imem_addr !== i_addr0 || pc_out !== i_addr0) stab_err++;
          if (icnt >= iwait) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = imem[bus.imem_addr];
            flog.push_back(bus.imem_addr);
            icnt = 0;
          end else icnt++;
        end else icnt = 0;
        if (!reset && bus.dmem_req) begin
          if (dcnt == 0) begin
            d_addr0 = bus.dmem_addr; d_we0 = bus.dmem_we;
            d_wdata0 = bus.dmem_wdata; d_pc0 = pc_out;
          end else if (bus.dmem_addr !== d_addr0 || bus.dmem_we !== d_we0 ||
                       bus.dmem_wdata !== d_wdata0 || pc_out !== d_pc0) stab_err++;
          if (dcnt >= dwait) begin
            bus.dmem_ack = 1'b1;
            if (bus.dmem_we) begin
              dmem[bus.dmem_addr] = bus.dmem_wdata;
              last_st_addr = bus.dmem_addr;
              last_st_data = bus.dmem_wdata;
              st_cnt++;
            end else bus.dmem_rdata = dmem[bus.dmem_addr];
            dcnt = 0;
          end else dcnt++;
        end else dcnt = 0;
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hD000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_to_halt(input int maxc);
    int n = 0;
    while (!halted && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("halt_reached", halted, 1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    logic [5:0] imm;
    logic [7:0] exp_res;
    logic [2:0] exp_flg;
  } vec_t;
  vec_t vecs [12];

  initial begin
    int         n;
    logic [7:0] nxt;
    vecs[0]  = '{4'h1, 8'h05, 8'h03, 6'h00, 8'h08, 3'b000};
    vecs[1]  = '{4'h2, 8'h03, 8'h05, 6'h00, 8'hFE, 3'b101};
    vecs[2]  = '{4'h1, 8'hFF, 8'h01, 6'h00, 8'h00, 3'b011};
    vecs[3]  = '{4'h2, 8'h05, 8'h05, 6'h00, 8'h00, 3'b010};
    vecs[4]  = '{4'h3, 8'hF0, 8'h3C, 6'h00, 8'h30, 3'b000};
    vecs[5]  = '{4'h4, 8'h80, 8'h01, 6'h00, 8'h81, 3'b100};
    vecs[6]  = '{4'h5, 8'hAA, 8'hAA, 6'h00, 8'h00, 3'b010};
    vecs[7]  = '{4'h6, 8'h7F, 8'h00, 6'h01, 8'h80, 3'b100};
    vecs[8]  = '{4'h6, 8'h05, 8'h00, 6'h3F, 8'h04, 3'b001};
    vecs[9]  = '{4'h1, 8'h80, 8'h80, 6'h00, 8'h00, 3'b011};
    vecs[10] = '{4'h2, 8'h00, 8'h01, 6'h00, 8'hFF, 3'b101};
    vecs[11] = '{4'h6, 8'h10, 8'h00, 6'h20, 8'hF0, 3'b100};

    reset = 1'b1;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    bus.imem_rdata = '0; bus.dmem_rdata = '0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    clear_imem();

    // Reset with acks pulsed while reset is held
    repeat (1) @(posedge clk);
    #2 bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    @(posedge clk);
    #2 bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("rst_imem_req", bus.imem_req, 1);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_dmem_we", bus.dmem_we, 0);
    chk("rst_dmem_addr", bus.dmem_addr, 0);
    chk("rst_dmem_wdata", bus.dmem_wdata, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    resp_en = 1'b1;

    // Minimum latency: NOP (2) + LD (3) + HALT (2) = 7 rising edges
    clear_imem();
    imem[0] = 16'h0000;
    imem[1] = enc(4'h8, 3'd1, 3'd0, 6'd0);
    iwait = 0; dwait = 0;
    reset = 1'b0;
    n = 0;
    while (!halted && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_edges", n, 7);
    chk("latency_illegal", illegal, 0);

    // Table-driven ALU vectors: LD r1,[0]; LD r2,[1]; op; ST r1,[2]; HALT
    for (int i = 0; i < 12; i++) begin
      clear_imem();
      imem[0] = enc(4'h8, 3'd1, 3'd0, 6'd0);
      imem[1] = enc(4'h8, 3'd2, 3'd0, 6'd1);
      imem[2] = (vecs[i].op == 4'h6) ? enc(4'h6, 3'd1, 3'd0, vecs[i].imm)
                                     : enc(vecs[i].op, 3'd1, 3'd2, 6'd0);
      imem[3] = enc(4'h9, 3'd1, 3'd0, 6'd2);
      dmem[0] = vecs[i].a; dmem[1] = vecs[i].b; dmem[2] = '0;
      iwait = i % 3; dwait = (i + 1) % 3;
      do_reset();
      run_to_halt(300);
      chk($sformatf("vec%0d_result", i), dmem[2], vecs[i].exp_res);
      chk($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flg);
      chk($sformatf("vec%0d_illegal", i), illegal, 0);
    end

    // Subtract with borrow, store, then BN +2 taken (4 -> 7)
    clear_imem();
    imem[0] = enc(4'h7, 3'd1, 3'd0, 6'd3);
    imem[1] = enc(4'h7, 3'd2, 3'd0, 6'd5);
    imem[2] = enc(4'h2, 3'd1, 3'd2, 6'd0);
    imem[3] = enc(4'h9, 3'd1, 3'd0, 6'd0);
    imem[4] = enc(4'hC, 3'd0, 3'd0, 6'd2);
    imem[7] = enc(4'h7, 3'd3, 3'd0, 6'd1);
    imem[8] = enc(4'h9, 3'd3, 3'd0, 6'd1);
    iwait = 0; dwait = 0; st_cnt = 0;
    dmem[0] = '0; dmem[1] = '0;
    flog.delete();
    do_reset();
    run_to_halt(200);
    chk("sub_store_data", dmem[0], 8'hFE);
    chk("sub_flags", flags, 3'b101);
    nxt = 8'hEE;
    for (int i = 0; i + 1 < flog.size(); i++) if (flog[i] == 8'd4) nxt = flog[i+1];
    chk("bn_taken_next_fetch", nxt, 8'd7);
    chk("bn_target_store", dmem[1], 8'd1);
    chk("sub_store_count", st_cnt, 2);

    // Wait states: 3 idle cycles before every ack
    clear_imem();
    imem[0] = enc(4'h8, 3'd3, 3'd0, 6'd4);
    imem[1] = enc(4'h9, 3'd3, 3'd0, 6'd5);
    dmem[4] = 8'h5A; dmem[5] = '0;
    iwait = 3; dwait = 3; stab_err = 0;
    do_reset();
    run_to_halt(200);
    chk("wait_st_data", last_st_data, 8'h5A);
    chk("wait_st_addr", last_st_addr, 6'd5);
    chk("wait_stability", stab_err, 0);
    chk("wait_halt_pc", pc_out, 8'd2);

    // PC wrap: JMP to 0xFF, ADDI r1,-1 there, next fetch at 0x00
    clear_imem();
    imem[0]   = enc(4'h6, 3'd3, 3'd0, 6'd1);
    imem[1]   = enc(4'h7, 3'd5, 3'd0, 6'd2);
    imem[2]   = enc(4'h2, 3'd5, 3'd3, 6'd0);
    imem[3]   = enc(4'hB, 3'd0, 3'd0, 6'd2);
    imem[4]   = enc(4'h6, 3'd2, 3'd0, 6'h3F);
    imem[5]   = enc(4'hA, 3'd0, 3'd2, 6'd0);
    imem[6]   = enc(4'h9, 3'd1, 3'd0, 6'd3);
    imem[255] = enc(4'h6, 3'd1, 3'd0, 6'h3F);
    dmem[3] = '0;
    iwait = 1; dwait = 0;
    flog.delete();
    do_reset();
    run_to_halt(400);
    nxt = 8'hEE;
    for (int i = 0; i + 1 < flog.size(); i++) if (flog[i] == 8'hFF) nxt = flog[i+1];
    chk("wrap_next_fetch", nxt, 8'h00);
    chk("wrap_store", dmem[3], 8'hFF);
    chk("wrap_flags", flags, 3'b010);

    // Illegal opcode: sticky stop, no further requests
    clear_imem();
    imem[0] = enc(4'h7, 3'd1, 3'd0, 6'd1);
    imem[1] = 16'hE000;
    imem[2] = enc(4'h9, 3'd1, 3'd0, 6'd0);
    iwait = 0; dwait = 0; st_cnt = 0;
    do_reset();
    run_to_halt(100);
    chk("ill_illegal", illegal, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.imem_req || bus.dmem_req) n++;
    end
    chk("ill_no_req_cycles", n, 0);
    chk("ill_no_store", st_cnt, 0);
    chk("ill_halted_sticky", halted, 1);

    // Reset mid-MEM wait: dmem_req drops asynchronously, store dropped
    clear_imem();
    imem[0] = enc(4'h7, 3'd1, 3'd0, 6'd9);
    imem[1] = enc(4'h9, 3'd1, 3'd0, 6'd7);
    dmem[7] = '0;
    iwait = 0; dwait = 5; st_cnt = 0;
    do_reset();
    n = 0;
    while (!bus.dmem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mrst_dmem_req_seen", bus.dmem_req, 1);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_dmem_req_async", bus.dmem_req, 0);
    chk("mrst_imem_req", bus.imem_req, 1);
    chk("mrst_imem_addr", bus.imem_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("mrst_store_dropped", st_cnt, 0);
    chk("mrst_mem_untouched", dmem[7], 8'h00);
    flog.delete();
    dwait = 0;
    reset = 1'b0;
    run_to_halt(100);
    chk("mrst_first_fetch", (flog.size() > 0) ? flog[0] : 8'hEE, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
